// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 key-schedule controller.
package aes_pkg;

  localparam int unsigned AES_NR    = 10;
  localparam int unsigned AES_KEY_W = 128;
  localparam int unsigned AES_IDX_W = 4;

  typedef logic [AES_KEY_W-1:0] aes_rk_t;
  typedef aes_rk_t [AES_NR:0]   aes_sched_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY,
    STREAM
  } aes_key_ctrl_state_e;

endpackage

// File: rtl/aes_key_ctrl.sv
// Sequences key loads into the AES-128 expander, waits for the schedule to
// settle, then streams round keys forward (encrypt) or reverse (decrypt).
module aes_key_ctrl
  import aes_pkg::*;
#(
  parameter int unsigned NR = AES_NR
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_req_vld_i,
  output logic                 key_req_rdy_o,
  input  logic [AES_KEY_W-1:0] key_req_key_i,
  output logic                 aes_key_vld_o,
  output logic [AES_KEY_W-1:0] aes_key_o,
  input  aes_sched_t           aes_key_sched_i,
  output logic                 key_ready_o,
  input  logic                 rk_start_i,
  input  logic                 rk_decrypt_i,
  output logic                 rk_vld_o,
  input  logic                 rk_rdy_i,
  output logic [AES_IDX_W-1:0] rk_idx_o,
  output logic [AES_KEY_W-1:0] rk_o,
  output logic                 rk_last_o,
  output logic                 rk_err_o
);

  localparam logic [AES_IDX_W-1:0] IDX_LAST = AES_IDX_W'(NR);
  localparam logic [AES_IDX_W-1:0] CNT_LAST = AES_IDX_W'(NR - 1);

  aes_key_ctrl_state_e   r_state;
  logic [AES_IDX_W-1:0]  r_cnt;
  logic [AES_IDX_W-1:0]  r_idx;
  logic                  r_vld;
  logic                  r_dec;
  logic                  r_err;
  logic                  r_key_ready;

  aes_key_ctrl_state_e   w_state_nxt;
  logic [AES_IDX_W-1:0]  w_cnt_nxt;
  logic [AES_IDX_W-1:0]  w_idx_nxt;
  logic                  w_vld_nxt;
  logic                  w_dec_nxt;
  logic                  w_err_nxt;
  logic                  w_key_req_rdy;
  logic                  w_last;

  // Last index depends on the latched direction; only meaningful while streaming.
  assign w_last = r_vld & (r_dec ? (r_idx == '0) : (r_idx == IDX_LAST));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_idx_nxt     = r_idx;
    w_vld_nxt     = r_vld;
    w_dec_nxt     = r_dec;
    w_err_nxt     = 1'b0;
    w_key_req_rdy = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_key_req_rdy = 1'b1;
        w_err_nxt     = rk_start_i;
        if (key_req_vld_i) begin
          w_state_nxt = EXPAND;
          w_cnt_nxt   = '0;
        end
      end
      EXPAND: begin
        w_err_nxt = rk_start_i;
        w_cnt_nxt = r_cnt + AES_IDX_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = READY;
        end
      end
      READY: begin
        // A stream start wins over a simultaneous key load.
        w_key_req_rdy = !rk_start_i;
        if (rk_start_i) begin
          w_state_nxt = STREAM;
          w_vld_nxt   = 1'b1;
          w_dec_nxt   = rk_decrypt_i;
          w_idx_nxt   = rk_decrypt_i ? IDX_LAST : '0;
        end else if (key_req_vld_i) begin
          w_state_nxt = EXPAND;
          w_cnt_nxt   = '0;
        end
      end
      STREAM: begin
        w_err_nxt = rk_start_i;
        if (r_vld && rk_rdy_i) begin
          if (w_last) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = READY;
          end else if (r_dec) begin
            w_idx_nxt = r_idx - AES_IDX_W'(1);
          end else begin
            w_idx_nxt = r_idx + AES_IDX_W'(1);
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_vld       <= 1'b0;
      r_dec       <= 1'b0;
      r_err       <= 1'b0;
      r_key_ready <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_idx       <= w_idx_nxt;
      r_vld       <= w_vld_nxt;
      r_dec       <= w_dec_nxt;
      r_err       <= w_err_nxt;
      r_key_ready <= (w_state_nxt == READY) || (w_state_nxt == STREAM);
    end
  end

  assign key_req_rdy_o = w_key_req_rdy;
  assign aes_key_vld_o = key_req_vld_i & w_key_req_rdy;
  assign aes_key_o     = key_req_key_i;
  assign key_ready_o   = r_key_ready;
  assign rk_vld_o      = r_vld;
  assign rk_idx_o      = r_idx;
  assign rk_o          = aes_key_sched_i[r_idx];
  assign rk_last_o     = w_last;
  assign rk_err_o      = r_err;

endmodule

// File: tb/tb_aes_key_ctrl.sv
// Scoreboard bench for aes_key_ctrl with a behavioural AES-128 key expander.
module tb_aes_key_ctrl;
  import aes_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       key_req_vld, key_req_rdy;
  aes_rk_t    key_req_key;
  logic       aes_key_vld;
  aes_rk_t    aes_key;
  aes_sched_t sched = '0;
  logic       key_ready;
  logic       rk_start, rk_decrypt, rk_vld, rk_rdy;
  logic [3:0] rk_idx;
  aes_rk_t    rk;
  logic       rk_last, rk_err;

  aes_key_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .key_req_vld_i(key_req_vld), .key_req_rdy_o(key_req_rdy), .key_req_key_i(key_req_key),
    .aes_key_vld_o(aes_key_vld), .aes_key_o(aes_key), .aes_key_sched_i(sched),
    .key_ready_o(key_ready), .rk_start_i(rk_start), .rk_decrypt_i(rk_decrypt),
    .rk_vld_o(rk_vld), .rk_rdy_i(rk_rdy), .rk_idx_o(rk_idx), .rk_o(rk),
    .rk_last_o(rk_last), .rk_err_o(rk_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_loads = 0;
  bit known_key = 1'b0;
  aes_sched_t ref_sched;

  typedef struct {
    logic [3:0] idx;
    aes_rk_t    rk;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // GF(2^8) arithmetic and S-box built from first principles.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p ^= a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    logic [7:0] base = x;
    logic [7:0] e = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gmul(r, base);
      base = gmul(base, base);
    end
    return r ^ rotl8(r, 1) ^ rotl8(r, 2) ^ rotl8(r, 3) ^ rotl8(r, 4) ^ 8'h63;
  endfunction

  function automatic aes_sched_t expand(input aes_rk_t key);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    aes_sched_t  s;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    return s;
  endfunction

  // Expander stand-in: whole schedule reloads on the load strobe.
  always @(posedge clk) begin
    if (aes_key_vld) begin
      sched <= expand(aes_key);
      n_loads++;
    end
  end

  // Monitor: every valid cycle must present the queue head; a handshake retires it.
  always @(negedge clk) begin
    if (rst_n && rk_vld) begin
      if (exp_q.size() == 0) begin
        chk("stray_rk_vld", rk_idx, 4'hf);
      end else begin
        chk("rk_idx", rk_idx, exp_q[0].idx);
        chk("rk_key", rk, exp_q[0].rk);
        chk("rk_last", rk_last, exp_q[0].last);
        if (rk_rdy) begin
          if (known_key && rk_idx == 4'd1) chk("rk_vec_idx1", rk, 128'ha0fafe1788542cb123a339392a6c7605);
          if (known_key && rk_idx == 4'd10) chk("rk_vec_idx10", rk, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_stream(input bit dec);
    exp_t e;
    for (int s = 0; s <= 10; s++) begin
      e.idx  = 4'(dec ? 10 - s : s);
      e.rk   = ref_sched[e.idx];
      e.last = (s == 10);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_ready;
    int c = 0;
    while (!key_ready && c < 40) begin
      @(negedge clk);
      c++;
    end
    chk("wait_key_ready", key_ready, 1'b1);
  endtask

  task automatic load_key(input aes_rk_t k);
    int c = 0;
    tick;
    key_req_vld = 1'b1;
    key_req_key = k;
    while (!key_req_rdy && c < 40) begin
      tick;
      c++;
    end
    tick;
    key_req_vld = 1'b0;
    ref_sched = expand(k);
    wait_ready;
  endtask

  // mode: 0 = always ready, 1 = ready toggles 1,0,1,0, 2 = random ready
  task automatic stream(input bit dec, input int mode, input bit hold_req, input bit collide);
    int cyc = 0;
    tick;
    rk_start   = 1'b1;
    rk_decrypt = dec;
    if (collide) begin
      key_req_vld = 1'b1;
      key_req_key = {$urandom, $urandom, $urandom, $urandom};
    end
    push_stream(dec);
    @(negedge clk);
    if (collide) begin
      chk("collide_req_rdy", key_req_rdy, 1'b0);
      chk("collide_key_vld", aes_key_vld, 1'b0);
    end
    tick;
    rk_start    = 1'b0;
    rk_decrypt  = 1'($urandom);
    key_req_vld = 1'b0;
    while (exp_q.size() > 0 && cyc < 200) begin
      rk_rdy = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom);
      if (hold_req) begin
        key_req_vld = 1'b1;
        key_req_key = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      if (hold_req) begin
        chk("stream_req_rdy", key_req_rdy, 1'b0);
        chk("stream_key_vld", aes_key_vld, 1'b0);
      end
      tick;
      cyc++;
    end
    if (exp_q.size() > 0) begin
      chk("stream_timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    rk_rdy = 1'b0;
    @(negedge clk);
    chk("stream_end_vld", rk_vld, 1'b0);
    chk("stream_end_key_ready", key_ready, 1'b1);
    if (hold_req) begin
      chk("back_ready_req_rdy", key_req_rdy, 1'b1);
      chk("back_ready_key_vld", aes_key_vld, 1'b1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int loads0;
    int c;
    aes_rk_t k2, k3;
    rst_n = 1'b0; key_req_vld = 1'b0; key_req_key = '0;
    rk_start = 1'b0; rk_decrypt = 1'b0; rk_rdy = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_rdy", key_req_rdy, 1'b1);
    chk("rst_key_ready", key_ready, 1'b0);
    chk("rst_rk_vld", rk_vld, 1'b0);
    chk("rst_rk_idx", rk_idx, 4'd0);
    chk("rst_rk_err", rk_err, 1'b0);
    rst_n = 1'b1;

    // Start request while IDLE: one error pulse, state unchanged.
    tick;
    rk_start = 1'b1;
    tick;
    rk_start = 1'b0;
    @(negedge clk);
    chk("idle_err_pulse", rk_err, 1'b1);
    chk("idle_err_req_rdy", key_req_rdy, 1'b1);
    tick;
    @(negedge clk);
    chk("idle_err_clear", rk_err, 1'b0);
    chk("idle_err_no_stream", rk_vld, 1'b0);

    // Known FIPS-197 key with exact settle timing.
    tick;
    key_req_vld = 1'b1;
    key_req_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    known_key = 1'b1;
    loads0 = n_loads;
    @(negedge clk);
    chk("load_strobe", aes_key_vld, 1'b1);
    tick;
    key_req_vld = 1'b0;
    ref_sched = expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("settle_key_ready_e%0d", k), key_ready, 1'(k == 10));
    end
    chk("single_load_pulse", 32'(n_loads - loads0), 32'd1);

    stream(1'b0, 0, 1'b0, 1'b0);
    stream(1'b1, 1, 1'b0, 1'b0);

    // Key requests held through a stream and then through the expansion.
    loads0 = n_loads;
    stream(1'b0, 2, 1'b1, 1'b0);
    k2 = key_req_key;
    tick;
    known_key = 1'b0;
    ref_sched = expand(k2);
    k3 = {$urandom, $urandom, $urandom, $urandom};
    key_req_key = k3;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      chk($sformatf("expand_key_ready_e%0d", k), key_ready, 1'(k == 10));
      chk($sformatf("expand_req_rdy_e%0d", k), key_req_rdy, 1'(k == 10));
    end
    tick;
    key_req_vld = 1'b0;
    ref_sched = expand(k3);
    chk("held_req_loads", 32'(n_loads - loads0), 32'd2);
    wait_ready;

    loads0 = n_loads;
    stream(1'b1, 2, 1'b0, 1'b1);
    chk("collide_no_load", 32'(n_loads - loads0), 32'd0);
    stream(1'b0, 1, 1'b0, 1'b0);

    // Reset in the middle of an encrypt stream.
    tick;
    rk_start = 1'b1;
    rk_decrypt = 1'b0;
    push_stream(1'b0);
    tick;
    rk_start = 1'b0;
    rk_rdy = 1'b1;
    c = 0;
    while (exp_q.size() > 6 && c < 50) begin
      tick;
      c++;
    end
    chk("pre_reset_idx", rk_idx, 4'd5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_rk_vld", rk_vld, 1'b0);
    chk("midrst_key_ready", key_ready, 1'b0);
    chk("midrst_rk_idx", rk_idx, 4'd0);
    chk("midrst_req_rdy", key_req_rdy, 1'b1);
    exp_q.delete();
    rk_rdy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_req_rdy", key_req_rdy, 1'b1);
    chk("postrst_key_ready", key_ready, 1'b0);
    chk("postrst_rk_vld", rk_vld, 1'b0);

    load_key({$urandom, $urandom, $urandom, $urandom});
    stream(1'b1, 2, 1'b0, 1'b0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
